// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: fetch-side lookup/refill controller for the two-way instruction cache.
// ICACHE_FILL_FWD_EN: when defined, the refilled word is forwarded from WR_HI without a re-lookup.
module icache_fill_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_req,
    input  logic [31:0]      fetch_addr,
    output logic             fetch_ready,
    output logic             fetch_valid,
    output logic [31:0]      fetch_data,
    output logic [31:0]      c_addr,
    output logic [31:0]      c_data_in,
    output logic             c_wren,
    output logic             c_rden,
    output logic             c_w_sel,
    input  logic [31:0]      c_data_out,
    input  logic             c_ready,
    input  logic             c_hit,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic             busy,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    typedef enum logic [2:0] {IDLE, LOOKUP, RESP, MEM_LO, WR_LO, MEM_HI, WR_HI} state_t;

    state_t      state, nxt;
    logic [31:0] a_q, w0, w1;
    logic        retry;
    logic        unused_c_ready;

    wire [31:0] line_lo = {a_q[31:3], 3'b000};
    wire [31:0] line_hi = {a_q[31:3], 3'b100};

    assign busy           = state != IDLE;
    assign unused_c_ready = c_ready;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    // next state and cache/memory port drive, all zero outside their owning states
    always_comb begin
        nxt         = state;
        fetch_ready = 1'b0;
        c_rden      = 1'b0;
        c_wren      = 1'b0;
        c_w_sel     = 1'b0;
        c_addr      = '0;
        c_data_in   = '0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        case (state)
            IDLE: begin
                fetch_ready = 1'b1;
                nxt         = fetch_req ? LOOKUP : IDLE;
            end
            LOOKUP: begin
                c_rden = 1'b1;
                c_addr = a_q;
                nxt    = c_hit ? RESP : MEM_LO;
            end
            RESP: nxt = IDLE;
            MEM_LO: begin
                mem_req  = 1'b1;
                mem_addr = line_lo;
                nxt      = mem_ack ? WR_LO : MEM_LO;
            end
            WR_LO: begin
                c_wren    = 1'b1;
                c_addr    = line_lo;
                c_data_in = w0;
                nxt       = MEM_HI;
            end
            MEM_HI: begin
                mem_req  = 1'b1;
                mem_addr = line_hi;
                nxt      = mem_ack ? WR_HI : MEM_HI;
            end
            WR_HI: begin
                c_wren    = 1'b1;
                c_w_sel   = 1'b1;
                c_addr    = line_hi;
                c_data_in = w1;
`ifdef ICACHE_FILL_FWD_EN
                nxt       = IDLE;
`else
                nxt       = LOOKUP;
`endif
            end
            default: nxt = IDLE;
        endcase
    end

    // request latch, refill words, response and first-lookup statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q         <= '0;
            w0          <= '0;
            w1          <= '0;
            retry       <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_data  <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
        end else begin
            fetch_valid <= 1'b0;
            if (state == IDLE && fetch_req) begin
                a_q   <= fetch_addr;
                retry <= 1'b0;
            end
            if (state == LOOKUP && !retry) begin
                if (c_hit && !(&hit_cnt))    hit_cnt  <= hit_cnt + 1'b1;
                if (!c_hit && !(&miss_cnt))  miss_cnt <= miss_cnt + 1'b1;
            end
            if (state == RESP) begin
                fetch_valid <= 1'b1;
                fetch_data  <= c_data_out;
            end
            if (state == MEM_LO && mem_ack) w0 <= mem_rdata;
            if (state == MEM_HI && mem_ack) w1 <= mem_rdata;
            if (state == WR_HI) begin
`ifdef ICACHE_FILL_FWD_EN
                fetch_valid <= 1'b1;
                fetch_data  <= a_q[2] ? w1 : w0;
`else
                retry       <= 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb_icache_fill_ctrl: directed vector bench with behavioural cache and memory models.
module tb_icache_fill_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_ready, fetch_valid, c_wren, c_rden, c_w_sel, mem_req, mem_ack, busy;
    logic [31:0] fetch_data, c_addr, c_data_in, mem_addr, mem_rdata;
    logic [31:0] c_data_out = '0;
    logic        c_ready = 1'b0;
    logic        c_hit;
    logic [15:0] hit_cnt, miss_cnt;

    int passed = 0;
    int total = 0;

    icache_fill_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .c_addr(c_addr), .c_data_in(c_data_in), .c_wren(c_wren), .c_rden(c_rden),
        .c_w_sel(c_w_sel), .c_data_out(c_data_out), .c_ready(c_ready), .c_hit(c_hit),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // direct-mapped stand-in for the cache: lower half staged, upper half commits tag/valid
    logic [31:0]  lo [128];
    logic [31:0]  hi [128];
    logic [21:0]  tag [128];
    logic [127:0] vld = '0;
    wire  [6:0]   idx = c_addr[9:3];
    assign c_hit = vld[idx] && tag[idx] == c_addr[31:10];
    always @(posedge clk) begin
        if (c_wren) begin
            if (!c_w_sel) lo[idx] <= c_data_in;
            else begin
                hi[idx]  <= c_data_in;
                tag[idx] <= c_addr[31:10];
                vld[idx] <= 1'b1;
            end
        end
        if (c_rden) c_data_out <= c_addr[2] ? hi[idx] : lo[idx];
        c_ready <= c_rden;
    end

    // memory: fixed words at 0x100/0x104, otherwise address-derived; ack after ack_delay waits
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == 32'h100 ? 32'hAAAA0000 : a == 32'h104 ? 32'hBBBB1111 : a ^ 32'h5A5A0000;
    endfunction
    int ack_delay = 0;
    int wait_cnt = 0;
    assign mem_rdata = mem_word(mem_addr);
    assign mem_ack   = mem_req && wait_cnt == ack_delay;
    always @(posedge clk) wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;

    // bus monitors sampled mid-cycle
    int         mem_cyc = 0, rden_cyc = 0, both_err = 0, unstable = 0;
    logic [1:0] wlog = '0;
    logic       prev_req = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;
    always @(negedge clk) begin
        if (mem_req) mem_cyc <= mem_cyc + 1;
        if (c_rden) rden_cyc <= rden_cyc + 1;
        if (c_rden && c_wren) both_err <= both_err + 1;
        if (c_wren) wlog <= {wlog[0], c_w_sel};
        if (mem_req && prev_req && !prev_ack && mem_addr != prev_addr) unstable <= unstable + 1;
        prev_req  <= mem_req;
        prev_ack  <= mem_ack;
        prev_addr <= mem_addr;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    typedef struct {
        logic [31:0] addr;
        int          dly;
        logic [31:0] data;
        int          lat;
        int          hits;
        int          misses;
        int          mcyc;
        int          rden;
        bit          miss;
    } vec_t;

`ifdef ICACHE_FILL_FWD_EN
    localparam int MISS_LAT = 5;
    localparam int RD_MISS  = 1;
`else
    localparam int MISS_LAT = 7;
    localparam int RD_MISS  = 2;
`endif

    task automatic do_fetch(input vec_t v);
        int lat, m0, r0;
        @(negedge clk);
        chk("ready_before_accept", fetch_ready, 1);
        fetch_addr = v.addr;
        fetch_req  = 1'b1;
        ack_delay  = v.dly;
        m0 = mem_cyc;
        r0 = rden_cyc;
        @(posedge clk);
        #1 fetch_req = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!fetch_valid && lat < 60);
        chk($sformatf("latency@%0h", v.addr), lat, v.lat);
        chk($sformatf("data@%0h", v.addr), fetch_data, v.data);
        chk("hit_cnt", hit_cnt, v.hits);
        chk("miss_cnt", miss_cnt, v.misses);
        @(posedge clk);
        #1 chk("valid_one_cycle", fetch_valid, 0);
        chk("mem_req_cycles", mem_cyc - m0, v.mcyc);
        chk("rden_cycles", rden_cyc - r0, v.rden);
        if (v.miss) chk("write_order", wlog, 2'b01);
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{32'h104, 0, 32'hBBBB1111, MISS_LAT,     0, 1, 2, RD_MISS, 1'b1};
        vecs[1] = '{32'h100, 0, 32'hAAAA0000, 2,            1, 1, 0, 1,       1'b0};
        vecs[2] = '{32'h108, 3, 32'h5A5A0108, MISS_LAT + 6, 1, 2, 8, RD_MISS, 1'b1};
        vecs[3] = '{32'h10C, 0, 32'h5A5A010C, 2,            2, 2, 0, 1,       1'b0};
        vecs[4] = '{32'h200, 0, 32'h5A5A0200, MISS_LAT,     2, 3, 2, RD_MISS, 1'b1};

        #2;
        chk("rst_ready", fetch_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid_data", {fetch_valid, fetch_data}, 0);
        chk("rst_counters", {hit_cnt, miss_cnt}, 0);
        chk("rst_mem", {mem_req, mem_addr}, 0);
        chk("rst_cache", {c_wren, c_rden, c_w_sel, c_addr, c_data_in}, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) do_fetch(vecs[i]);

        // back-to-back hits: request held, re-accepted on the edge that clears fetch_valid
        begin
            logic [5:0] pat;
            @(negedge clk);
            fetch_addr = 32'h100;
            fetch_req  = 1'b1;
            @(posedge clk);
            for (int e = 0; e < 6; e++) begin
                @(posedge clk);
                #1 pat[5-e] = fetch_valid;
                if (e == 2) chk("b2b_reaccept_busy", busy, 1);
                if (e == 4) fetch_req = 1'b0;
            end
            chk("b2b_valid_pattern", pat, 6'b010010);
            chk("b2b_hit_cnt", hit_cnt, 4);
            chk("b2b_data", fetch_data, 32'hAAAA0000);
        end

        // reset during the upper-half memory read
        begin
            int n = 0;
            @(negedge clk);
            fetch_addr = 32'h300;
            fetch_req  = 1'b1;
            ack_delay  = 3;
            @(posedge clk);
            #1 fetch_req = 1'b0;
            while (!(mem_req && mem_addr == 32'h304) && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("reached_mem_hi", n < 40, 1);
            reset = 1'b0;
            #1;
            chk("async_rst_idle", {busy, fetch_ready}, 2'b01);
            chk("async_rst_outputs", {mem_req, c_wren, c_rden, fetch_valid}, 0);
            chk("async_rst_counters", {hit_cnt, miss_cnt}, 0);
            @(negedge clk);
            reset = 1'b1;
            do_fetch('{32'h300, 0, 32'h5A5A0300, MISS_LAT, 0, 1, 2, RD_MISS, 1'b1});
        end

        chk("rden_wren_exclusive", both_err, 0);
        chk("mem_addr_stable", unstable, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Fetch-side controller and initiator for the two-way instruction cache.
- Accepts fetch requests and issues cache lookups on the cache read port.
- On a miss, reads the 64-bit line from memory as two 32-bit words, then writes it into the cache: lower word first (w_sel=0), upper word last (w_sel=1, which sets tag/valid/LRU).
- Then re-looks-up and returns the instruction word. It also keeps hit/miss counters.

Parameters:
- CNT_W, 16, width of saturating hit/miss counters.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  32  byte address of the requested word.
- fetch_ready  out  1  high in IDLE; a request is accepted when fetch_req & fetch_ready.
- fetch_valid  out  1  one-cycle pulse; fetch_data is valid.
- fetch_data  out  32  returned instruction word.
- c_addr  out  32  cache address.
- c_data_in  out  32  cache write data.
- c_wren  out  1  cache write enable.
- c_rden  out  1  cache read enable.
- c_w_sel  out  1  cache half select; 1 = upper word, which commits tag/valid.
- c_data_out  in  32  cache read data, registered by the cache.
- c_ready  in  1  cache read-done; informational only.
- c_hit  in  1  cache combinational hit for c_addr.
- mem_req  out  1  memory read request.
- mem_addr  out  32  memory word address.
- mem_ack  in  1  memory acknowledge; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  memory read data.
- busy  out  1  state != IDLE.
- hit_cnt  out  CNT_W  first-lookup hits.
- miss_cnt  out  CNT_W  first-lookup misses.

Behaviour:
- Reset (reset=0, asynchronous, any state):
  - state=IDLE; retry flag=0.
  - fetch_valid=0, fetch_data=0, hit_cnt=0, miss_cnt=0, mem_req=0; all c_* outputs 0.
  - An aborted refill may leave a lower half written without valid; this is harmless.
- States: IDLE, LOOKUP, RESP, MEM_LO, WR_LO, MEM_HI, WR_HI.
- IDLE:
  - fetch_ready=1.
  - On accept: latch fetch_addr into A, clear retry, go to LOOKUP.
- LOOKUP (one cycle):
  - c_rden=1, c_addr=A.
  - Sample c_hit at the edge. Hit: go to RESP. Miss: go to MEM_LO.
  - Counters change only when retry=0: hit_cnt+1 on hit, miss_cnt+1 on miss. Both saturate at all-ones.
- RESP (one cycle): at its edge, fetch_data<=c_data_out, fetch_valid<=1, go to IDLE.
- fetch_valid:
  - Cleared on the next edge.
  - A new request may be accepted on the same edge that clears it (back-to-back).
- MEM_LO:
  - mem_req=1, mem_addr={A[31:3],3'b000}, held stable until mem_ack is sampled high.
  - On ack: W0<=mem_rdata, go to WR_LO.
  - mem_ack in the first request cycle is legal.
- WR_LO (one cycle): c_wren=1, c_w_sel=0, c_addr={A[31:3],3'b000}, c_data_in=W0. Go to MEM_HI.
- MEM_HI: as MEM_LO with mem_addr={A[31:3],3'b100}, latch W1. Go to WR_HI.
- WR_HI (one cycle): c_wren=1, c_w_sel=1, c_addr={A[31:3],3'b100}, c_data_in=W1. Set retry, go to LOOKUP.
- A retry LOOKUP that misses refills again; counters do not change.
- c_wren and c_rden are never high together. Outside the states above, all c_* and mem_* outputs are 0.
- The controller does not use the cache write_done; every write is exactly one cycle.
- mem_req drops the cycle after ack.
- fetch_req outside IDLE is ignored; the requester must hold it.
- Latency (accept edge = E0):
  - Hit: fetch_valid high after E2.
  - Miss with zero-wait memory: fetch_valid high after E7.

Optional Feature:
- ICACHE_FILL_FWD_EN defined:
  - WR_HI goes directly to IDLE.
  - At the WR_HI edge: fetch_valid<=1, fetch_data <= A[2] ? W1 : W0. No retry lookup.
  - Zero-wait miss latency: fetch_valid after E5.
- Undefined: behaviour as above, with re-lookup through the cache.

Test Plan:
- After reset, with fetch_req=0 -> all outputs 0; fetch_ready=1; hit_cnt=miss_cnt=0.
- Cold fetch 0x00000104; memory returns 0xAAAA0000 @0x100 and 0xBBBB1111 @0x104 with immediate ack:
  - Write sequence w_sel=0 then w_sel=1.
  - fetch_data=0xBBBB1111 seven cycles after accept.
  - miss_cnt=1, hit_cnt=0.
- Refetch 0x00000100 -> fetch_data=0xAAAA0000 two cycles after accept; no mem_req; hit_cnt=1.
- Miss with mem_ack delayed 3 cycles -> mem_req/mem_addr stable for 4 cycles; latency +6 versus zero-wait.
- reset pulsed low during MEM_HI -> state IDLE immediately. Refetch of the same line misses; mem_req toggles again.
- ICACHE_FILL_FWD_EN build, cold fetch 0x00000200 -> fetch_data=word @0x200 five cycles after accept; no extra c_rden.
